// File: rtl/hyperbus_delay_ctrl.sv
// Multi-channel programmable delay block for the HyperBus PHY.
// Taps change glitch-free: gate the cell, settle, switch tap, settle, ungate.

module generic_delay_D4_O1_3P750_CG0 (
  input  logic       clk_i,
  input  logic       enable_i,
  input  logic [3:0] delay_i,
  output logic       clk_o
);
  // Stand-in model: tap delay is not timed, gating is.
  logic unused_delay;
  assign unused_delay = ^delay_i;
  assign clk_o = clk_i & enable_i;
endmodule

module hyperbus_delay_ctrl #(
  parameter int unsigned NumChannels  = 2,
  parameter int unsigned SettleCycles = 4,
  parameter logic [3:0]  ResetDelay   = 4'd8,
  localparam int unsigned ChanW = $clog2(NumChannels + 1),
  localparam int unsigned CntW  = $clog2(SettleCycles + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [ChanW-1:0]         cfg_chan_i,
  input  logic                     cfg_bcast_i,
  input  logic [3:0]               cfg_delay_i,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     busy_o,
  input  logic [NumChannels-1:0]   in_i,
  output logic [NumChannels-1:0]   out_o,
  output logic [4*NumChannels-1:0] delay_o
);

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    SWITCH
  } state_t;

  state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [NumChannels-1:0] mask_q, mask_d;
  logic [NumChannels-1:0] en_q, en_d;
  logic [NumChannels-1:0][3:0] taps_q, taps_d;
  logic [3:0] req_q, req_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic ready_q, ready_d;

  logic [NumChannels-1:0] dec_mask;
  logic bad_chan;
  logic same;
  logic last;

  assign bad_chan = !cfg_bcast_i &&
                    (32'(cfg_chan_i) >= NumChannels);
  assign last = (cnt_q == CntW'(SettleCycles - 1));

  always_comb begin
    dec_mask = '0;
    same = 1'b1;
    for (int k = 0; k < NumChannels; k++) begin
      dec_mask[k] = cfg_bcast_i ||
                    (32'(cfg_chan_i) == 32'(k));
      if (dec_mask[k] && taps_q[k] != cfg_delay_i)
        same = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    en_d    = en_q;
    taps_d  = taps_q;
    req_d   = req_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid_i) begin
          if (bad_chan) begin
            err_d = 1'b1;
          end else if (same) begin
            done_d = 1'b1;
          end else begin
            state_d = GATE;
            cnt_d   = '0;
            mask_d  = dec_mask;
            req_d   = cfg_delay_i;
            en_d    = en_q & ~dec_mask;
          end
        end
      end
      GATE: begin
        if (last) begin
          state_d = SWITCH;
          cnt_d   = '0;
          for (int k = 0; k < NumChannels; k++)
            if (mask_q[k]) taps_d[k] = req_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SWITCH: begin
        if (last) begin
          state_d = IDLE;
          cnt_d   = '0;
          en_d    = '1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      en_q    <= '1;
      taps_q  <= {NumChannels{ResetDelay}};
      req_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      en_q    <= en_d;
      taps_q  <= taps_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign cfg_ready_o = ready_q;
  assign busy_o      = ~ready_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign delay_o     = taps_q;

  for (genvar g = 0; g < NumChannels; g++) begin : g_cell
    generic_delay_D4_O1_3P750_CG0 u_cell (
      .clk_i    (in_i[g]),
      .enable_i (en_q[g]),
      .delay_i  (taps_q[g]),
      .clk_o    (out_o[g])
    );
  end

endmodule
